// File: rtl/addsub_sched.sv
// addsub_sched: four-requester add/subtract unit with one shared datapath.
// An arbiter grants one requester per operation (round-robin or fixed
// priority). The operation then passes through IDLE -> EXEC -> RESP, and
// the result is held in RESP until the consumer accepts it.
// Optional feature: define ADDSUB_SCHED_STATS_EN to build the saturating
// completed-operation counter behind op_count. Without it op_count reads 0.
module addsub_sched #(
    parameter int data_width     = 8,
    parameter int fixed_priority = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              req_valid,
    output logic [3:0]              req_ready,
    input  logic [3:0]              req_op,
    input  logic [4*data_width-1:0] req_a,
    input  logic [4*data_width-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_id,
    output logic [data_width:0]     rsp_result,
    output logic                    busy,
    output logic [15:0]             op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state_q,  state_d;
    logic [1:0]            ptr_q,    ptr_d;
    logic                  op_q,     op_d;
    logic [data_width-1:0] a_q,      a_d;
    logic [data_width-1:0] b_q,      b_d;
    logic [1:0]            id_q,     id_d;
    logic [data_width:0]   result_q, result_d;

    logic                  found_s;
    logic [1:0]            win_s;
    logic [1:0]            base_s;
    logic [1:0]            idx_s;
    logic                  grant_s;
    logic                  rsp_fire_s;

    // Arbiter: scan upward from the search base and wrap at 3 -> 0. The first valid index wins.
    always_comb begin
        found_s = 1'b0;
        win_s   = 2'd0;
        idx_s   = 2'd0;
        if (fixed_priority != 0) begin
            base_s = 2'd0;
        end else begin
            base_s = ptr_q;
        end
        for (int k = 0; k < 4; k++) begin
            idx_s = base_s + 2'(k);
            if (!found_s && req_valid[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant qualification: offer a grant only from IDLE and never while reset is held.
    always_comb begin
        if ((state_q == IDLE) && !rst && found_s) begin
            grant_s   = 1'b1;
            req_ready = 4'b0001 << win_s;
        end else begin
            grant_s   = 1'b0;
            req_ready = 4'b0000;
        end
    end

    assign rsp_fire_s = (state_q == RESP) && rsp_ready;

    // Next-state logic: capture the winner on grant, compute in EXEC, hold in RESP until accepted.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    op_d    = req_op[win_s];
                    a_d     = req_a[int'(win_s)*data_width +: data_width];
                    b_d     = req_b[int'(win_s)*data_width +: data_width];
                    id_d    = win_s;
                    ptr_d   = win_s + 2'd1;
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                // The extra MSB holds the carry on add and the borrow on subtract.
                if (op_q) begin
                    result_d = {1'b0, a_q} - {1'b0, b_q};
                end else begin
                    result_d = {1'b0, a_q} + {1'b0, b_q};
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            op_q     <= 1'b0;
            a_q      <= {data_width{1'b0}};
            b_q      <= {data_width{1'b0}};
            id_q     <= 2'd0;
            result_q <= {(data_width+1){1'b0}};
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            result_q <= result_d;
        end
    end

    // Response outputs come from registers. They are forced to idle values while reset is asserted.
    always_comb begin
        if (rst) begin
            rsp_valid  = 1'b0;
            busy       = 1'b0;
            rsp_id     = 2'd0;
            rsp_result = {(data_width+1){1'b0}};
        end else begin
            rsp_valid  = (state_q == RESP);
            busy       = (state_q != IDLE);
            rsp_id     = id_q;
            rsp_result = result_q;
        end
    end

`ifdef ADDSUB_SCHED_STATS_EN
    logic [15:0] count_q, count_d;

    // Completed-operation counter: counts accepted responses and stops at all-ones.
    always_comb begin
        if (rsp_fire_s && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    // Counter output, forced to zero while reset is asserted.
    always_comb begin
        if (rst) begin
            op_count = 16'h0000;
        end else begin
            op_count = count_q;
        end
    end
`else
    logic unused_fire_s;
    assign unused_fire_s = rsp_fire_s;
    assign op_count      = 16'h0000;
`endif

endmodule

// File: tb/tb_addsub_sched.sv
// tb_addsub_sched: directed, table-driven bench for addsub_sched, with
// hand-written sequences for arbitration, backpressure and reset corner cases.
module tb_addsub_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [8:0]  rsp_result;
    logic        busy;
    logic [15:0] op_count;

    // Second instance in fixed-priority mode. It shares all inputs with the first.
    logic [3:0]  fp_req_ready;
    logic        fp_rsp_valid;
    logic [1:0]  fp_rsp_id;
    logic [8:0]  fp_rsp_result;
    logic        fp_busy;
    logic [15:0] fp_op_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    addsub_sched #(.data_width(8), .fixed_priority(0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .busy(busy), .op_count(op_count)
    );

    addsub_sched #(.data_width(8), .fixed_priority(1)) dut_fp (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(fp_req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(fp_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id), .rsp_result(fp_rsp_result),
        .busy(fp_busy), .op_count(fp_op_count)
    );

    always #5 clk = ~clk;

    // Cycle counter used to measure the spacing between grants.
    always @(posedge clk) cyc <= cyc + 1;

    // Global time limit, so a stuck design still ends the run.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic [1:0] id;
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // A single operation from one requester, with rsp_ready held high.
    // Call it in IDLE, about 1 time unit after a rising edge.
    task automatic do_op(input logic [1:0] id, input logic op, input logic [7:0] a,
                         input logic [7:0] b, input logic [8:0] exp);
        req_valid = 4'b0001 << id;
        req_op[id] = op;
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        #1 chk("grant", {28'd0, req_ready}, {28'd0, 4'b0001 << id});
        tick;
        // The request and its operands change after the grant. The result must not change.
        req_valid = 4'b0000;
        req_a = ~req_a;
        req_b = ~req_b;
        req_op = ~req_op;
        #1 chk("exec_busy", {31'd0, busy}, 32'd1);
        chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("exec_req_ready", {28'd0, req_ready}, 32'd0);
        tick;
        #1 chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("resp_id", {30'd0, rsp_id}, {30'd0, id});
        chk("resp_result", {23'd0, rsp_result}, {23'd0, exp});
        tick;
        #1 chk("back_idle", {31'd0, busy}, 32'd0);
    endtask

    logic [8:0] exp_rr[4];
    int         last_cyc;
    int         got;

    initial begin
        vecs[0] = '{id: 2'd0, op: 1'b0, a: 8'hFF, b: 8'h01, exp: 9'h100};
        vecs[1] = '{id: 2'd2, op: 1'b1, a: 8'h05, b: 8'h07, exp: 9'h1FE};
        vecs[2] = '{id: 2'd1, op: 1'b0, a: 8'h12, b: 8'h34, exp: 9'h046};
        vecs[3] = '{id: 2'd3, op: 1'b1, a: 8'h80, b: 8'h01, exp: 9'h07F};
        vecs[4] = '{id: 2'd0, op: 1'b1, a: 8'h00, b: 8'h00, exp: 9'h000};
        vecs[5] = '{id: 2'd3, op: 1'b0, a: 8'hFF, b: 8'hFF, exp: 9'h1FE};
        vecs[6] = '{id: 2'd1, op: 1'b1, a: 8'h00, b: 8'hFF, exp: 9'h101};
        vecs[7] = '{id: 2'd2, op: 1'b0, a: 8'h00, b: 8'h00, exp: 9'h000};
        exp_rr[0] = 9'h001;
        exp_rr[1] = 9'h012;
        exp_rr[2] = 9'h023;
        exp_rr[3] = 9'h034;

        // Reset state. Requests are presented during reset and must not be granted.
        rst = 1'b1;
        req_valid = 4'hF;
        req_op = 4'h0;
        req_a = 32'h0;
        req_b = 32'h0;
        rsp_ready = 1'b1;
        tick;
        tick;
        #1 chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("rst_rsp_result", {23'd0, rsp_result}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        req_valid = 4'h0;
        rst = 1'b0;
        tick;

        // Single-requester vectors from the table.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Round-robin: pulse reset so the pointer returns to 0, then hold all four requests valid.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = {i[3:0], 4'h1};
            req_b[i*8 +: 8] = 8'(i);
        end
        req_op = 4'h0;
        req_valid = 4'hF;
        last_cyc = 0;
        for (int g = 0; g < 5; g++) begin
            got = 0;
            for (int n = 0; n < 8 && got == 0; n++) begin
                #1;
                if (req_ready != 4'b0000) got = 1;
                else tick;
            end
            chk("rr_grant_seen", got, 32'd1);
            chk("rr_grant", {28'd0, req_ready}, {28'd0, 4'b0001 << (g % 4)});
            chk("fp_grant", {28'd0, fp_req_ready}, 32'd1);
            if (g > 0) chk("rr_spacing", cyc - last_cyc, 32'd3);
            last_cyc = cyc;
            tick;
            tick;
            #1 chk("rr_rsp_id", {30'd0, rsp_id}, g % 4);
            chk("rr_rsp_result", {23'd0, rsp_result}, {23'd0, exp_rr[g % 4]});
            chk("fp_rsp_id", {30'd0, fp_rsp_id}, 32'd0);
            tick;
        end
        req_valid = 4'h0;
        tick;

        // Backpressure: the pointer is 1 here, so requester 2 is the only one asking.
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        req_op[2] = 1'b1;
        req_a[23:16] = 8'h40;
        req_b[23:16] = 8'h01;
        #1 chk("bp_grant", {28'd0, req_ready}, 32'h4);
        tick;
        req_valid = 4'hF;
        tick;
        for (int n = 0; n < 5; n++) begin
            #1 chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_result", {23'd0, rsp_result}, 32'h03F);
            chk("bp_rsp_id", {30'd0, rsp_id}, 32'd2);
            chk("bp_req_ready", {28'd0, req_ready}, 32'd0);
            tick;
        end
        rsp_ready = 1'b1;
        #1 chk("bp_hold_ready", {28'd0, req_ready}, 32'd0);
        tick;
        #1 chk("bp_regrant", {28'd0, req_ready}, 32'h8);
        // Drop the request before the edge. It is never transferred.
        req_valid = 4'h0;
        tick;
        #1 chk("drop_no_grant", {31'd0, busy}, 32'd0);

        // Reset while in RESP. The pointer is still 3, so the search 3, 0 selects requester 0.
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        req_op[0] = 1'b0;
        req_a[7:0] = 8'h01;
        req_b[7:0] = 8'h02;
        #1 chk("rr_wrap_grant", {28'd0, req_ready}, 32'h1);
        tick;
        req_valid = 4'h0;
        tick;
        #1 chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        #1 chk("in_rst_valid", {31'd0, rsp_valid}, 32'd0);
        tick;
        rst = 1'b0;
        #1 chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_count", {16'd0, op_count}, 32'd0);
        // A grant is possible in the first cycle after reset is released.
        rsp_ready = 1'b1;
        do_op(2'd1, 1'b0, 8'h10, 8'h20, 9'h030);
        do_op(2'd3, 1'b1, 8'h10, 8'h20, 9'h1F0);
        do_op(2'd0, 1'b0, 8'h7F, 8'h81, 9'h100);
`ifdef ADDSUB_SCHED_STATS_EN
        chk("stats_count", {16'd0, op_count}, 32'd3);
`else
        chk("stats_count", {16'd0, op_count}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
